piso_serializer: RTL and testbench

- Parallel-in/serial-out stage that feeds the 1101 Moore sequence detector's serial input `x`.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out MSB-first at one bit per clock, with a qualifying valid flag.
- Supports back-to-back words with no idle gap, so the detector sees a continuous bit stream.

---
 rtl/piso_serializer.sv | 97 +++++++++
 tb/tb_piso_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit word in, MSB-first bit stream out to the 1101 detector.
// Latency: MSB on x_out one cycle after the accepting edge, then one bit per clock (plus parity cycle with PISO_PARITY_EN).
// Backpressure: load_ready only in IDLE or on the last cycle of a frame; back-to-back words stream with no gap.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after each word.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;     // MSB is the bit currently on x_out
  logic [CW-1:0]    cnt;      // bits remaining after the one on x_out
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q;    // even parity of the word in flight
`endif

  // Status decoded from registered state only; ready opens on the final cycle of a frame.
`ifdef PISO_PARITY_EN
  assign done       = (state == PARITY);
  assign load_ready = (state == IDLE) || (state == PARITY);
`else
  assign done       = (state == SHIFT) && (cnt == '0);
  assign load_ready = (state == IDLE) || done;
`endif
  assign busy   = (state != IDLE);
  assign accept = load_valid && load_ready;
  assign x_out  = sreg[WIDTH-1];

  // Frame FSM: accept has priority (it is only possible on a frame's last cycle or in IDLE),
  // otherwise shift, emit parity, or fall back to IDLE with outputs cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      x_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      state   <= SHIFT;
      sreg    <= load_data;
      cnt     <= CNT_MAX;
      x_valid <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= ^load_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            sreg <= sreg << 1;
            cnt  <= cnt - CW'(1);
          end else begin
`ifdef PISO_PARITY_EN
            state   <= PARITY;
            sreg    <= {par_q, {(WIDTH-1){1'b0}}};
            x_valid <= 1'b1;
`else
            state   <= IDLE;
            sreg    <= '0;
            x_valid <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          sreg    <= '0;
          cnt     <= '0;
          x_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: frame-level reference model checked every cycle, plus literal frame checks.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
  localparam logic [31:0] S_BITS = 32'h1A1,   S_R = 32'h7FF, S_D = 32'h400;
  localparam logic [31:0] B_BITS = 32'h3421B, B_R = 32'h403;
  localparam logic [31:0] I_BITS = 32'h343FE;
  localparam logic [31:0] R_BITS = 32'h161;
  localparam logic [31:0] C_BITS = 32'h180;
`else
  localparam int FL = W;
  localparam logic [31:0] S_BITS = 32'hD0,   S_R = 32'h3FF, S_D = 32'h200;
  localparam logic [31:0] B_BITS = 32'hD00D, B_R = 32'h203;
  localparam logic [31:0] I_BITS = 32'hD0FF;
  localparam logic [31:0] R_BITS = 32'hB0;
  localparam logic [31:0] C_BITS = 32'hC0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, x_out, x_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of bits; m_idx points at the bit being shown.
  logic m_frame [FL];
  int   m_idx = 0;
  bit   m_act = 1'b0;

  function automatic bit m_ready();
    return !m_act || (m_idx == FL - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act = 1'b0;
    end else if (load_valid && m_ready()) begin
      for (int i = 0; i < W; i++) m_frame[i] = load_data[W-1-i];
`ifdef PISO_PARITY_EN
      m_frame[FL-1] = ^load_data;
`endif
      m_idx = 0;
      m_act = 1'b1;
    end else if (m_act) begin
      if (m_idx == FL - 1) m_act = 1'b0;
      else m_idx++;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    check("x_valid", x_valid, m_act);
    check("x_out", x_out, m_act ? m_frame[m_idx] : 1'b0);
    check("busy", busy, m_act);
    check("done", done, m_act && (m_idx == FL - 1));
    check("load_ready", load_ready, m_ready());
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Offer word a, optionally offer b from cycle sc (0 = never), and record 2*FL+1 cycles.
  task automatic frame_run(input logic [W-1:0] a, input logic [W-1:0] b, input int sc,
                           output logic [31:0] bits, output int nb,
                           output logic [31:0] rmask, output logic [31:0] dmask);
    logic acc;
    bits = '0; nb = 0; rmask = '0; dmask = '0;
    load_data = a; load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
    for (int c = 1; c <= 2 * FL + 1; c++) begin
      if (c == sc) begin load_data = b; load_valid = 1'b1; end
      if (x_valid) begin bits = {bits[30:0], x_out}; nb++; end
      rmask = {rmask[30:0], load_ready};
      dmask = {dmask[30:0], done};
      acc = load_ready && load_valid;
      cyc();
      if (acc) load_valid = 1'b0;
    end
  endtask

  logic [31:0] bits, rmask, dmask;
  int          nb;
  logic        acc;

  initial begin
    // Reset held 3 cycles; the compare process checks idle outputs throughout.
    repeat (3) cyc();
    lit("reset_ready", {31'd0, load_ready}, 32'd1);
    lit("reset_xvalid", {31'd0, x_valid}, 32'd0);
    reset = 1'b1;
    cyc();

    frame_run(8'hD0, 8'h00, 0, bits, nb, rmask, dmask);
    lit("single_bits", bits, S_BITS);
    lit("single_len", nb, FL);
    lit("single_ready", rmask, S_R);
    lit("single_done", dmask, S_D);

    frame_run(8'hD0, 8'h0D, 1, bits, nb, rmask, dmask);
    lit("b2b_bits", bits, B_BITS);
    lit("b2b_len", nb, 2 * FL);
    lit("b2b_ready", rmask, B_R);

    frame_run(8'hD0, 8'hFF, 2, bits, nb, rmask, dmask);
    lit("ignore_bits", bits, I_BITS);
    lit("ignore_ready", rmask, B_R);

    frame_run(8'hC0, 8'h00, 0, bits, nb, rmask, dmask);
    lit("c0_bits", bits, C_BITS);

    // Reset in cycle 4 of an 8'hD0 frame: output must drop immediately.
    load_data = 8'hD0; load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
    repeat (3) cyc();
    lit("mid_valid_before", {31'd0, x_valid}, 32'd1);
    reset = 1'b0;
    #1;
    lit("mid_reset_xvalid", {31'd0, x_valid}, 32'd0);
    lit("mid_reset_busy", {31'd0, busy}, 32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    frame_run(8'hB0, 8'h00, 0, bits, nb, rmask, dmask);
    lit("after_reset_bits", bits, R_BITS);
    lit("after_reset_len", nb, FL);

    // Random traffic: producer holds its word until accepted; occasional resets.
    for (int i = 0; i < 3000; i++) begin
      acc = load_ready && load_valid;
      cyc();
      if (acc || !load_valid) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = W'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        cyc();
        reset = 1'b1;
      end
    end
    load_valid = 1'b0;
    repeat (2 * FL) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
